// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pc_sel codes (common with the decoder) and the sequencer state encoding.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-step operation.
package cpu_pkg;

    localparam logic [2:0] PCSEL_INC = 3'd0;
    localparam logic [2:0] PCSEL_JMP = 3'd1;
    localparam logic [2:0] PCSEL_JE  = 3'd2;
    localparam logic [2:0] PCSEL_JNE = 3'd3;
    localparam logic [2:0] PCSEL_HLT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE = 3'd7
`endif
    } seq_state_t;

    // True when the PC loads the jump target; codes 101..111 fall through as INC.
    function automatic logic take_jump(input logic [2:0] sel, input logic flag);
        case (sel)
            PCSEL_INC: take_jump = 1'b0;
            PCSEL_JMP: take_jump = 1'b1;
            PCSEL_JE:  take_jump = flag;
            PCSEL_JNE: take_jump = ~flag;
            default:   take_jump = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts ack-less FETCH cycles; expire fires on the ack-less cycle that would bring the count to MAX_WAIT.
module fetch_watchdog #(
    parameter int MAX_WAIT = 15,
    localparam int CNT_W = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM of the 16-bit CPU: owns PC, compare flag and instruction register.
// Build option SEQ_SINGLE_STEP_EN adds the step input; each retire then waits in PAUSE for a step pulse.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    input  logic [2:0]      pc_sel,
    input  logic [15:0]     jump_target,
    input  logic            cmp_write,
    input  logic            alu_eq,
    input  logic            dec_reg_w_en,
    input  logic            dec_mem_w_en,
    output logic            reg_w_en,
    output logic            mem_w_en,
    output logic [PC_W-1:0] pc,
    output logic            cmp_flag,
    output logic            retire,
    output logic            halted,
    output logic            fault,
    output logic [2:0]      state_dbg
);

    // imem handshake: imem_req rises on FETCH entry and holds until the cycle imem_ack=1;
    // imem_rdata is taken in that same cycle and imem_req is low from the next cycle on.

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            cmp_flag_q, cmp_flag_d;
    logic [2:0]      sel_q, sel_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            reg_w_en_q, reg_w_en_d;
    logic            mem_w_en_q, mem_w_en_d;
    logic            retire_q, retire_d;
    logic            imem_req_q, imem_req_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic wd_clear;
    logic wd_en;
    logic wd_expire;

    assign wd_clear = (state_q != S_FETCH);
    assign wd_en    = (state_q == S_FETCH) && !imem_ack;

    fetch_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_fetch_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cmp_flag_d = cmp_flag_q;
        sel_d      = sel_q;
        tgt_d      = tgt_q;
        reg_w_en_d = 1'b0;
        mem_w_en_d = 1'b0;
        retire_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (wd_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = (pc_sel == PCSEL_HLT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // Strobes and retire are registered here so they appear exactly in the WB cycle.
                sel_d      = pc_sel;
                tgt_d      = PC_W'(jump_target);
                reg_w_en_d = dec_reg_w_en;
                mem_w_en_d = dec_mem_w_en;
                retire_d   = 1'b1;
                state_d    = S_WB;
            end
            S_WB: begin
                if (cmp_write) begin
                    cmp_flag_d = alu_eq;
                end
                pc_d = take_jump(sel_q, cmp_flag_q) ? tgt_q : pc_q + PC_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                state_d = S_PAUSE;
`else
                state_d = S_FETCH;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        imem_req_d = (state_d == S_FETCH);
        halted_d   = (state_d == S_HALT);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            cmp_flag_q <= 1'b0;
            sel_q      <= PCSEL_INC;
            tgt_q      <= '0;
            reg_w_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            retire_q   <= 1'b0;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            cmp_flag_q <= cmp_flag_d;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            reg_w_en_q <= reg_w_en_d;
            mem_w_en_q <= mem_w_en_d;
            retire_q   <= retire_d;
            imem_req_q <= imem_req_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign reg_w_en  = reg_w_en_q;
    assign mem_w_en  = mem_w_en_q;
    assign pc        = pc_q;
    assign cmp_flag  = cmp_flag_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a small decoder model, a randomized imem responder and an
// instruction-level reference model with an expected-retire queue.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int W        = 19;  // {reg_w, mem_w, cmp_after, pc_after[15:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr;
    logic [2:0]  pc_sel;
    logic [15:0] jump_target;
    logic        cmp_write;
    logic        alu_eq;
    logic        dec_reg_w_en;
    logic        dec_mem_w_en;
    logic        reg_w_en;
    logic        mem_w_en;
    logic [15:0] pc;
    logic        cmp_flag;
    logic        retire;
    logic        halted;
    logic        fault;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_W     (16),
        .RESET_PC (16'h0000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .pc_sel       (pc_sel),
        .jump_target  (jump_target),
        .cmp_write    (cmp_write),
        .alu_eq       (alu_eq),
        .dec_reg_w_en (dec_reg_w_en),
        .dec_mem_w_en (dec_mem_w_en),
        .reg_w_en     (reg_w_en),
        .mem_w_en     (mem_w_en),
        .pc           (pc),
        .cmp_flag     (cmp_flag),
        .retire       (retire),
        .halted       (halted),
        .fault        (fault),
        .state_dbg    (state_dbg)
    );

    // Bench-side decoder: op = w[15:12]; 0 HLT, 1 JMP, 2 JE, 3 JNE, 4 CMP, 5 ADD, 6 STORE,
    // 7..9 map to the unknown pc_sel codes 5..7, the rest are INC with enables from low bits.
    function automatic logic [2:0] dec_sel(input logic [15:0] w);
        case (w[15:12])
            4'h0:    return PCSEL_HLT;
            4'h1:    return PCSEL_JMP;
            4'h2:    return PCSEL_JE;
            4'h3:    return PCSEL_JNE;
            4'h7:    return 3'd5;
            4'h8:    return 3'd6;
            4'h9:    return 3'd7;
            default: return PCSEL_INC;
        endcase
    endfunction
    function automatic logic [15:0] dec_tgt(input logic [15:0] w);
        return {{4{w[11]}}, w[11:0]};
    endfunction
    function automatic logic dec_cw(input logic [15:0] w);
        return (w[15:12] == 4'h4) || (w[15:12] >= 4'h7 && w[6]);
    endfunction
    function automatic logic dec_rw(input logic [15:0] w);
        return (w[15:12] == 4'h5) || (w[15:12] >= 4'h7 && w[4]);
    endfunction
    function automatic logic dec_mw(input logic [15:0] w);
        return (w[15:12] == 4'h6) || (w[15:12] >= 4'h7 && w[5]);
    endfunction

    assign pc_sel       = dec_sel(instr);
    assign jump_target  = dec_tgt(instr);
    assign cmp_write    = dec_cw(instr);
    assign alu_eq       = instr[0];
    assign dec_reg_w_en = dec_rw(instr);
    assign dec_mem_w_en = dec_mw(instr);

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           ack_cyc_q[$];
    logic [15:0]  prog_q[$];

    logic [15:0] model_pc;
    logic        model_cmp;
    bit          model_halt, model_fault;
    bit          in_rst = 1'b1;
    bit          withhold, zero_wait, pend_chk;
    logic [15:0] pend_pc;
    logic        pend_cmp;
    int          fetch_wait, plan, min_plan, max_plan, last_ret, pause_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instruction-level reference: applies one fetched word to the architectural state.
    task automatic model_fetch(input logic [15:0] w);
        logic [2:0]  sel;
        logic [15:0] nxt;
        logic        cmp_after;
        sel = dec_sel(w);
        if (sel == PCSEL_HLT) begin
            model_halt = 1'b1;
        end else begin
            nxt = model_pc + 16'd1;
            if (sel == PCSEL_JMP || (sel == PCSEL_JE && model_cmp) || (sel == PCSEL_JNE && !model_cmp))
                nxt = dec_tgt(w);
            cmp_after = dec_cw(w) ? w[0] : model_cmp;
            exp_q.push_back({dec_rw(w), dec_mw(w), cmp_after, nxt});
            ack_cyc_q.push_back(cyc);
            model_pc  = nxt;
            model_cmp = cmp_after;
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        logic [15:0]  w;
        int           a;
        if (pend_chk) begin
            check("pc_after", pc, pend_pc);
            check("cmp_after", cmp_flag, pend_cmp);
            pend_chk = 1'b0;
        end
        if (retire) begin
            if (exp_q.size() == 0) begin
                check("retire_spurious", retire, 0);
            end else begin
                e = exp_q.pop_front();
                a = ack_cyc_q.pop_front();
                check("latency", cyc - a, 3);
                check("reg_w_en", reg_w_en, e[18]);
                check("mem_w_en", mem_w_en, e[17]);
                pend_cmp = e[16];
                pend_pc  = e[15:0];
                pend_chk = 1'b1;
                if (zero_wait && last_ret >= 0) check("retire_period", cyc - last_ret, 4);
                last_ret   = cyc;
                pause_left = $urandom_range(1, 3);
            end
        end else begin
            check("strobe_idle", {reg_w_en, mem_w_en}, 0);
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'($urandom_range(0, 1));  // ignored outside PAUSE
        if (pause_left > 0 && !retire) begin
            check("pause_req", imem_req, 0);
            pause_left--;
            step = (pause_left == 0);
        end
`endif
        if (imem_req) begin
            if (fetch_wait == 0) check("imem_addr", imem_addr, model_pc);
            if (!withhold && fetch_wait == plan && prog_q.size() > 0) begin
                w          = prog_q.pop_front();
                imem_ack   = 1'b1;
                imem_rdata = w;
                model_fetch(w);
                fetch_wait = 0;
                plan       = $urandom_range(min_plan, max_plan);
            end else begin
                fetch_wait++;
                if (fetch_wait == MAX_WAIT) begin
                    check("fault_early", fault, 0);
                    model_fault = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (!in_rst) monitor();
    endtask

    task automatic model_clear();
        model_pc    = 16'h0000;
        model_cmp   = 1'b0;
        model_halt  = 1'b0;
        model_fault = 1'b0;
        exp_q.delete();
        ack_cyc_q.delete();
        prog_q.delete();
        fetch_wait  = 0;
        pend_chk    = 1'b0;
        pause_left  = 0;
        last_ret    = -1;
        withhold    = 1'b0;
        zero_wait   = 1'b0;
        min_plan    = 0;
        max_plan    = 0;
        plan        = 0;
    endtask

    task automatic do_reset();
        in_rst   = 1'b1;
        rst      = 1'b1;
        start    = 1'b0;
        step     = 1'b0;
        imem_ack = 1'b0;
        cycle();
        cycle();
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        check("rst_cmp", cmp_flag, 0);
        check("rst_req", imem_req, 0);
        check("rst_outs", {halted, fault, retire, reg_w_en, mem_w_en}, 0);
        rst = 1'b0;
        model_clear();
        in_rst = 1'b0;
    endtask

    task automatic run_prog();
        int n;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (!(model_halt && exp_q.size() == 0) && !model_fault && n < 2000) begin
            cycle();
            n++;
        end
        if (n >= 2000) check("prog_timeout", 1, 0);
        cycle();
        cycle();
        check("halted", halted, 1);
        check("pc_final", pc, model_pc);
        check("cmp_final", cmp_flag, model_cmp);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        model_clear();

        // 1: ADD stream with zero-wait acks
        do_reset();
`ifndef SEQ_SINGLE_STEP_EN
        zero_wait = 1'b1;
`endif
        prog_q = '{16'h5012, 16'h5012, 16'h5012, 16'h0000};
        run_prog();
        check("t1_pc", pc, 16'h0003);

        // 2: CMP then JE, taken and not taken
        do_reset();
        prog_q = '{16'h4001, 16'h2020, 16'h0000};
        run_prog();
        check("t2_cmp_taken", cmp_flag, 1);
        check("t2_pc_taken", pc, 16'h0020);
        do_reset();
        prog_q = '{16'h4000, 16'h2020, 16'h0000};
        run_prog();
        check("t2_cmp_fall", cmp_flag, 0);
        check("t2_pc_fall", pc, 16'h0002);

        // 3: JMP to FFFF then INC wraps
        do_reset();
        prog_q = '{16'h1FFF, 16'h5012, 16'h0000};
        run_prog();
        check("t3_wrap", pc, 16'h0000);

        // 4: HALT is sticky and ignores start
        do_reset();
        prog_q = '{16'h0000};
        run_prog();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("t4_halt_sticky", halted, 1);
        check("t4_req_idle", imem_req, 0);
        check("t4_pc_frozen", pc, 16'h0000);

        // 5: fetch timeout, then reset with a late ack
        do_reset();
        withhold = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (!model_fault && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) check("fault_timeout", 1, 0);
        cycle();
        check("t5_fault", fault, 1);
        check("t5_req_drop", imem_req, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("t5_fault_sticky", fault, 1);
        in_rst     = 1'b1;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        cycle();
        rst = 1'b0;
        cycle();
        imem_ack = 1'b0;
        check("t5_late_ack_instr", instr, 16'h0000);
        check("t5_late_ack_req", imem_req, 0);
        check("t5_fault_clr", fault, 0);
        cycle();
        check("t5_idle_stays", imem_req, 0);

        // Reset during an in-flight fetch drops req on the same edge
        do_reset();
        withhold = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        check("inflight_req", imem_req, 1);
        in_rst = 1'b1;
        rst = 1'b1;
        cycle();
        check("inflight_rst_req", imem_req, 0);

        // Boundary: ack on the last cycle before timeout
        do_reset();
        min_plan = MAX_WAIT - 1;
        max_plan = MAX_WAIT - 1;
        plan     = MAX_WAIT - 1;
        prog_q = '{16'h6123, 16'h3005, 16'h0000};
        run_prog();
        check("edge_no_fault", fault, 0);

        // Randomized programs with random ack waits
        for (int t = 0; t < 6; t++) begin
            int len;
            do_reset();
            max_plan = $urandom_range(0, 4);
            plan     = $urandom_range(0, max_plan);
            len = $urandom_range(8, 20);
            for (int i = 0; i < len; i++)
                prog_q.push_back({4'($urandom_range(1, 15)), 12'($urandom)});
            prog_q.push_back({4'h0, 12'($urandom)});
            run_prog();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
